// File: rtl/dcnt_pkg.sv
// ---------------------------------------------------------------------------
// dcnt_pkg
// Shared definitions for the down_counter_timer slice.
//   dcnt_state_t      : FSM encoding (ST_IDLE / ST_RUN)
//   DCNT_WIDTH_DEF    : default count width
//   DCNT_PRESC_W_DEF  : default prescale width
// ---------------------------------------------------------------------------
package dcnt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dcnt_state_t;

    localparam int DCNT_WIDTH_DEF   = 32;
    localparam int DCNT_PRESC_W_DEF = 8;

endpackage

// File: rtl/dcnt_prescaler.sv
// ---------------------------------------------------------------------------
// dcnt_prescaler
// Tick generator for the down counter. Produces one tick every prescale+1
// cycles in which run is high; holds its count while run is low.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   clr       in  synchronous clear (timer load)
//   run       in  count enable (timer running, enabled, not cancelled)
//   prescale  in  tick divider, compared live against the internal count
//   tick      out combinational tick, valid while run is high
// ---------------------------------------------------------------------------
module dcnt_prescaler
    import dcnt_pkg::*;
#(
    parameter int PRESCALE_W = DCNT_PRESC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt;

    // Equality (not >=) on purpose: if prescale is lowered below the current
    // count, the counter runs on, wraps through zero and matches later.
    assign tick = run & (presc_cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (clr) begin
            presc_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
// Loadable, prescaled down-counter with a one-cycle done pulse at terminal
// count. Optional periodic mode via macro DCNT_AUTORELOAD_EN: terminal count
// reloads the last loaded value and keeps running.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   load      in  load request (highest synchronous priority)
//   load_val  in  start value; zero forces IDLE with count 0
//   prescale  in  tick divider, tick period = prescale+1 enabled cycles
//   enable    in  run/pause
//   cancel    in  abort run, count held
//   count     out current count
//   busy      out high while running
//   done      out one-cycle pulse at terminal count
// ---------------------------------------------------------------------------
module down_counter_timer
    import dcnt_pkg::*;
#(
    parameter int WIDTH      = DCNT_WIDTH_DEF,
    parameter int PRESCALE_W = DCNT_PRESC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  cancel,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    dcnt_state_t      state;
    dcnt_state_t      state_next;
    logic [WIDTH-1:0] count_next;
    logic             done_next;
    logic             tick;
    logic             presc_run;

`ifdef DCNT_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] reload_next;
`endif

    assign busy = (state == ST_RUN);

    // Cancel must freeze the prescaler as well as the count.
    assign presc_run = busy & enable & ~cancel;

    dcnt_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .run      (presc_run),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            done       <= 1'b0;
`ifdef DCNT_AUTORELOAD_EN
            reload_val <= '0;
`endif
        end else begin
            count      <= count_next;
            done       <= done_next;
`ifdef DCNT_AUTORELOAD_EN
            reload_val <= reload_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        done_next   = 1'b0;
`ifdef DCNT_AUTORELOAD_EN
        reload_next = reload_val;
`endif
        if (load) begin
            if (load_val != '0) begin
                count_next  = load_val;
                state_next  = ST_RUN;
`ifdef DCNT_AUTORELOAD_EN
                reload_next = load_val;
`endif
            end else begin
                count_next = '0;
                state_next = ST_IDLE;
            end
        end else if (cancel) begin
            state_next = ST_IDLE;
        end else if (tick) begin
            if (count > WIDTH'(1)) begin
                count_next = count - WIDTH'(1);
            end else begin
                // Terminal count; <= 1 also covers a zero count so the
                // counter can never wrap below zero.
                done_next = 1'b1;
`ifdef DCNT_AUTORELOAD_EN
                count_next = reload_val;
`else
                count_next = '0;
                state_next = ST_IDLE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    localparam int W  = 32;
    localparam int PW = 8;
`ifdef DCNT_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [PW-1:0] prescale = '0;
    logic          enable = 1'b0;
    logic          cancel = 1'b0;
    logic [W-1:0]  count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .prescale (prescale),
        .enable   (enable),
        .cancel   (cancel),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [W-1:0] cnt;
        bit           running;
        int           ticks_seen;   // enabled cycles since last tick
        logic [W-1:0] period_val;
        bit           pulse;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n = s;
        n.pulse = 1'b0;
        if (load) begin
            n.ticks_seen = 0;
            n.cnt        = load_val;
            n.running    = (load_val != 0);
            if (load_val != 0) n.period_val = load_val;
        end else if (cancel) begin
            n.running = 1'b0;
        end else if (s.running && enable) begin
            if (s.ticks_seen == int'(prescale)) begin
                n.ticks_seen = 0;
                if (s.cnt > 1) begin
                    n.cnt = s.cnt - 1;
                end else begin
                    n.pulse = 1'b1;
                    if (AUTORELOAD) n.cnt = s.period_val;
                    else begin
                        n.cnt     = 0;
                        n.running = 1'b0;
                    end
                end
            end else begin
                n.ticks_seen = (s.ticks_seen + 1) % (1 << PW);
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.cnt        <= '0;
            m.running    <= 1'b0;
            m.ticks_seen <= 0;
            m.period_val <= '0;
            m.pulse      <= 1'b0;
        end else begin
            m <= model_next(m);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One compare process against the model, every cycle.
    always @(negedge clk) begin
        check("model_count", 64'(count), 64'(m.cnt));
        check("model_busy",  64'(busy),  64'(m.running));
        check("model_done",  64'(done),  64'(m.pulse));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] c, input logic b, input logic d);
        check({tag, "_count"}, 64'(count), 64'(c));
        check({tag, "_busy"},  64'(busy),  64'(b));
        check({tag, "_done"},  64'(done),  64'(d));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        // Idle after reset: nothing moves, enable toggling irrelevant.
        for (int i = 0; i < 20; i++) begin
            enable = i[0];
            step();
            expect_out("idle", '0, 1'b0, 1'b0);
        end

`ifndef DCNT_AUTORELOAD_EN
        // prescale 0, load 3: 3,2,1,0 with done at 0.
        prescale = 0;
        enable = 1'b1;
        do_load(3);
        expect_out("p0_l3_a", 3, 1'b1, 1'b0);
        step(); expect_out("p0_l3_b", 2, 1'b1, 1'b0);
        step(); expect_out("p0_l3_c", 1, 1'b1, 1'b0);
        step(); expect_out("p0_l3_d", 0, 1'b0, 1'b1);
        step(); expect_out("p0_l3_e", 0, 1'b0, 1'b0);

        // prescale 3, load 2: done 8 edges after the load edge.
        prescale = 3;
        do_load(2);
        expect_out("p3_load", 2, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 4)      expect_out("p3_two", 2, 1'b1, 1'b0);
            else if (i < 8) expect_out("p3_one", 1, 1'b1, 1'b0);
            else            expect_out("p3_end", 0, 1'b0, 1'b1);
        end

        // Pause: load 5, hold at 3 for 5 disabled cycles.
        prescale = 0;
        do_load(5);
        expect_out("pause_l", 5, 1'b1, 1'b0);
        step(); expect_out("pause_4", 4, 1'b1, 1'b0);
        step(); expect_out("pause_3", 3, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); expect_out("pause_hold", 3, 1'b1, 1'b0);
        end
        enable = 1'b1;
        step(); expect_out("pause_2", 2, 1'b1, 1'b0);
        step(); expect_out("pause_1", 1, 1'b1, 1'b0);
        step(); expect_out("pause_0", 0, 1'b0, 1'b1);

        // Load on the terminal edge wins: no done.
        do_load(1);
        expect_out("coll_l1", 1, 1'b1, 1'b0);
        do_load(7);
        expect_out("coll_l7", 7, 1'b1, 1'b0);
        step(); expect_out("coll_6", 6, 1'b1, 1'b0);

        // Zero load stops the run.
        do_load(0);
        expect_out("zero_load", 0, 1'b0, 1'b0);

        // Cancel holds the count.
        do_load(4);
        step();
        cancel = 1'b1;
        step(); expect_out("cancel", 3, 1'b0, 1'b0);
        cancel = 1'b0;
        step(); expect_out("cancel_idle", 3, 1'b0, 1'b0);
`else
        // Periodic: 2,1,2,1 with done on each reload edge.
        prescale = 0;
        enable = 1'b1;
        do_load(2);
        expect_out("ar_2a", 2, 1'b1, 1'b0);
        step(); expect_out("ar_1a", 1, 1'b1, 1'b0);
        step(); expect_out("ar_2b", 2, 1'b1, 1'b1);
        step(); expect_out("ar_1b", 1, 1'b1, 1'b0);
        step(); expect_out("ar_2c", 2, 1'b1, 1'b1);
        cancel = 1'b1;
        step(); expect_out("ar_cancel", 2, 1'b0, 1'b0);
        cancel = 1'b0;
        step(); expect_out("ar_idle", 2, 1'b0, 1'b0);
`endif

        // Asynchronous reset mid-run takes effect immediately.
        prescale = 0;
        enable = 1'b1;
        do_load(9);
        step();
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // Randomised phase, checked by the model compare process.
        for (int i = 0; i < 3000; i++) begin
            load   = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 31) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            cancel = ($urandom_range(0, 39) == 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0)
                prescale = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 255)) : PW'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        load = 1'b0;
        cancel = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
